extmem_sync: RTL
================

# extmem_sync

Parametrised synchronous external-memory model with a request/acknowledge handshake, programmable wait states, a bounded depth with error reporting, and a hardware clear engine. It sits between the `micro` core and the bench's program/data store. It is the clocked successor to the combinational 64x8 `extmem`, so bus timing and slow-memory behaviour can be exercised in RTL and gate-level simulation.

## Interface
- `DW`, 8, data width in bits.
- `AW`, 6, address width in bits.
- `DEPTH`, 64, number of implemented words; 1 ≤ DEPTH ≤ 2^AW.
- `WAIT`, 0, extra wait-state cycles per access; 0..15.
- `INIT_VAL`, 0, DW-bit value written to every word by the clear engine.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_clr`  in  1  request a full clear; sampled only in IDLE.
- `mem_req`  in  1  access request; sampled only in IDLE.
- `mem_we`  in  1  1 = write, 0 = read; captured with `mem_req`.
- `mem_addr`  in  AW  word address; captured with `mem_req`.
- `mem_din`  in  DW  write data; captured with `mem_req`.
- `mem_dout`  out  DW  registered read data.
- `mem_ack`  out  1  one-cycle completion pulse.
- `mem_err`  out  1  valid with `mem_ack`; 1 = address ≥ DEPTH.
- `mem_busy`  out  1  high whenever the state is not IDLE.

## Operation
- Storage: DEPTH x DW array, no reset on the array itself; contents are initialised only by the clear engine.
- State machine: CLEAR, IDLE, WAIT, ACK.
- CLEAR:
  - A 0..DEPTH-1 counter writes INIT_VAL to each word, one word per edge.
  - The edge that writes DEPTH-1 moves to IDLE.
  - `mem_req` is ignored and not queued.
- IDLE:
  - `mem_clr`=1 → CLEAR with counter 0. `mem_clr` has priority over `mem_req` on the same edge; that request is dropped.
  - `mem_req`=1 → latch `mem_we`, `mem_addr`, `mem_din`. Inputs may change after the acceptance edge.
  - If WAIT=0, the access is performed on the acceptance edge and the state goes to ACK.
  - Otherwise the wait counter loads WAIT and the state goes to WAIT.
- WAIT: the counter decrements each edge. The edge on which it equals 1 performs the access and moves to ACK.
- Access:
  - Write with latched address < DEPTH: array updated.
  - Read with latched address < DEPTH: `mem_dout` ← array word.
  - Address ≥ DEPTH: write discarded, read loads `mem_dout` ← 0, `mem_err` set.
- ACK:
  - `mem_ack`=1 for exactly one cycle, then IDLE.
  - `mem_req` is not sampled in ACK. A request still high at the following IDLE edge is a new access.
- `mem_dout` holds its value until the next read completes. Writes do not change it.
- `mem_err` is cleared at the next acceptance and is meaningful only while `mem_ack`=1.

## Timing
- Reset asserted, asynchronous: state=CLEAR, clear counter=0, wait counter=0, `mem_dout`=0, `mem_ack`=0, `mem_err`=0, `mem_busy`=1.
- After reset deassertion: the first clear write happens on the first rising edge. `mem_busy` falls after DEPTH edges.
- Access latency: request sampled at edge k. The access happens at edge k+WAIT. `mem_ack` is high in the cycle after edge k+WAIT.
- Throughput: one access per WAIT+2 cycles.
- Read data is valid in the ack cycle and stable afterwards.
- Reset mid-access or mid-clear:
  - Immediate abort; outputs take reset values.
  - A pending access is lost and no ack is issued.
  - The clear restarts from address 0.
- Clear triggered by `mem_clr` accepted at edge k: addresses 0..DEPTH-1 written at edges k+1..k+DEPTH. IDLE is reached after edge k+DEPTH.
- Wrap-around:
  - Addresses do not wrap. Any address ≥ DEPTH flags an error.
  - The clear counter stops at DEPTH-1 and never wraps.

## Test plan
- Reset release, DEPTH=64: `mem_busy` high for exactly 64 cycles. Reads of 0x00, 0x1F and 0x3F then return INIT_VAL=0 with `mem_err`=0.
- WAIT=0: write 8'hAA to 0x01 accepted at edge k gives `mem_ack` in the cycle after edge k. Read of 0x01 accepted at edge k+2 returns 8'hAA with ack after edge k+2.
- WAIT=3: read of 0x02 holding 8'h55, accepted at edge k, gives `mem_ack` only in the cycle after edge k+3. `mem_busy` is high from after k through the ack cycle.
- DEPTH=48: write 8'h77 to 0x30 gives an ack with `mem_err`=1 and the array unchanged. Read of 0x30 gives `mem_dout`=0 and `mem_err`=1. Read of 0x2F gives `mem_err`=0.
- `mem_req` held high during CLEAR: no ack until clear ends, then exactly one access. `mem_clr` and `mem_req` in the same IDLE cycle: clear runs and the request is dropped.
- `reset` asserted during WAIT (WAIT=5) of a write of 8'h3C to 0x05: no `mem_ack`; outputs read as reset values. After the clear, 0x05 reads 0.

Source files
------------

// File: rtl/extmem_sync_if.sv
// extmem_sync_if
//   Bus bundle between a requester (the micro core or a bench) and the
//   extmem_sync word memory.
//
//   Request/acknowledge handshake:
//     The master raises mem_req together with mem_we/mem_addr/mem_din.
//     The slave samples them only on a rising edge where it is idle
//     (mem_busy low before that edge). Once a request is accepted, the
//     master may change or drop all request signals. Completion is a
//     single-cycle mem_ack pulse. mem_err and mem_dout are valid in that
//     cycle. mem_clr requests a full clear. It is also sampled only while
//     idle, and it wins over a simultaneous mem_req.
//
//   Signals (master view):
//     mem_clr  out  request full clear to INIT_VAL
//     mem_req  out  access request
//     mem_we   out  1 = write, 0 = read
//     mem_addr out  word address (AW bits)
//     mem_din  out  write data (DW bits)
//     mem_dout in   registered read data
//     mem_ack  in   one-cycle completion pulse
//     mem_err  in   address out of range, valid with mem_ack
//     mem_busy in   slave not idle
interface extmem_sync_if #(
    parameter int DW = 8,
    parameter int AW = 6
);
    logic          mem_clr;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic          mem_ack;
    logic          mem_err;
    logic          mem_busy;

    modport master (
        output mem_clr, mem_req, mem_we, mem_addr, mem_din,
        input  mem_dout, mem_ack, mem_err, mem_busy
    );

    modport slave (
        input  mem_clr, mem_req, mem_we, mem_addr, mem_din,
        output mem_dout, mem_ack, mem_err, mem_busy
    );
endinterface

// File: rtl/extmem_sync.sv
// extmem_sync
//   Clocked external-memory model: a DEPTH x DW array behind a
//   request/acknowledge bus. It supports programmable wait states,
//   out-of-range error reporting and a hardware clear engine. The clear
//   engine runs after every reset and on each mem_clr request.
//
//   Ports:
//     clk       in   single clock, rising edge
//     reset     in   asynchronous, active-low reset
//     bus       slave modport of extmem_sync_if (request/ack bus)
//     dbg_state out  current FSM state (CLEAR=0, IDLE=1, WAIT=2, ACK=3)
module extmem_sync #(
    parameter int            DW       = 8,
    parameter int            AW       = 6,
    parameter int            DEPTH    = 64,
    parameter int            WAIT     = 0,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic               clk,
    input  logic               reset,
    extmem_sync_if.slave       bus,
    output logic [1:0]         dbg_state
);
    localparam int            CW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST    = CW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [3:0]    WAIT_W  = 4'(WAIT);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] clr_cnt_q, clr_cnt_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          err_q, err_d;

    // Storage carries no reset; only the clear engine initialises it.
    logic [DW-1:0] mem_q [DEPTH];

    logic          arr_we;
    logic [CW-1:0] arr_addr;
    logic [DW-1:0] arr_data;

    logic          acc_go;
    logic          acc_we;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_din;
    logic          acc_in_range;
    logic [CW-1:0] acc_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= '0;
            wait_cnt_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            dout_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            dout_q     <= dout_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            mem_q[arr_addr] <= arr_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        wait_cnt_d = wait_cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        din_d      = din_q;
        dout_d     = dout_q;
        err_d      = err_q;
        arr_we     = 1'b0;
        arr_addr   = clr_cnt_q;
        arr_data   = INIT_VAL;
        acc_go     = 1'b0;
        // Outside the acceptance edge, the access uses the latched request.
        acc_we     = we_q;
        acc_addr   = addr_q;
        acc_din    = din_q;

        case (state_q)
            ST_CLEAR: begin
                arr_we = 1'b1;
                if (clr_cnt_q == LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (bus.mem_clr) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else if (bus.mem_req) begin
                    we_d   = bus.mem_we;
                    addr_d = bus.mem_addr;
                    din_d  = bus.mem_din;
                    err_d  = 1'b0;
                    if (WAIT == 0) begin
                        // No wait states: perform the access on the acceptance
                        // edge directly from the bus inputs.
                        acc_go   = 1'b1;
                        acc_we   = bus.mem_we;
                        acc_addr = bus.mem_addr;
                        acc_din  = bus.mem_din;
                        state_d  = ST_ACK;
                    end else begin
                        wait_cnt_d = WAIT_W;
                        state_d    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q == 4'd1) begin
                    acc_go  = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        // Out-of-range addresses never wrap onto implemented words.
        acc_in_range = ({1'b0, acc_addr} < DEPTH_W);
        acc_idx      = acc_addr[CW-1:0];

        if (acc_go) begin
            if (acc_we) begin
                if (acc_in_range) begin
                    arr_we   = 1'b1;
                    arr_addr = acc_idx;
                    arr_data = acc_din;
                end
            end else begin
                dout_d = acc_in_range ? mem_q[acc_idx] : '0;
            end
            err_d = !acc_in_range;
        end
    end

    assign bus.mem_dout = dout_q;
    assign bus.mem_ack  = (state_q == ST_ACK);
    assign bus.mem_err  = err_q;
    assign bus.mem_busy = (state_q != ST_IDLE);
    assign dbg_state    = state_q;
endmodule
